// File: rtl/main_mem_line_if.sv
// Request/grant bundle between the data cache and line-granular main memory.
// The cache drives the master side; the memory answers on the slave side.
interface main_mem_line_if #(
  parameter int LINE_ADDR_LEN = 1,
  parameter int ADDR_LEN      = 12
);
  localparam int LW = 32 << LINE_ADDR_LEN;

  logic                rd_req;
  logic                wr_req;
  logic [ADDR_LEN-1:0] addr;
  logic [LW-1:0]       wr_line;
  logic [LW-1:0]       rd_line;
  logic                gnt;
  logic                busy;
  logic [31:0]         rd_count;
  logic [31:0]         wr_count;

  modport master (
    output rd_req, wr_req, addr, wr_line,
    input  rd_line, gnt, busy, rd_count, wr_count
  );

  modport slave (
    input  rd_req, wr_req, addr, wr_line,
    output rd_line, gnt, busy, rd_count, wr_count
  );
endinterface

// File: rtl/main_mem_line.sv
// Fixed-latency line memory behind the data cache: refill reads, writebacks,
// and completed-access counters for miss-penalty statistics.
module main_mem_line #(
  parameter int LINE_ADDR_LEN = 1,
  parameter int ADDR_LEN      = 12,
  parameter int LATENCY       = 10
) (
  input logic            clk,
  input logic            rst,
  main_mem_line_if.slave bus
);
  localparam int LW    = 32 << LINE_ADDR_LEN;
  localparam int DEPTH = 1 << ADDR_LEN;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_GNT
  } state_t;

  state_t              r_state;
  state_t              w_state_n;
  logic [7:0]          r_cnt;
  logic                r_op_wr;
  logic [ADDR_LEN-1:0] r_addr;
  logic [LW-1:0]       r_wline;
  logic [LW-1:0]       r_rd_line;
  logic [31:0]         r_rd_count;
  logic [31:0]         r_wr_count;
  logic [LW-1:0]       r_mem [DEPTH];

  logic w_req;
  logic w_done;

  assign w_req  = bus.rd_req | bus.wr_req;
  assign w_done = (r_state == S_BUSY) && (r_cnt == 8'd0);

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_IDLE:  if (w_req) w_state_n = S_BUSY;
      S_BUSY:  if (r_cnt == 8'd0) w_state_n = S_GNT;
      S_GNT:   w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_op_wr    <= 1'b0;
      r_addr     <= '0;
      r_wline    <= '0;
      r_rd_line  <= '0;
      r_rd_count <= 32'd0;
      r_wr_count <= 32'd0;
    end else begin
      r_state <= w_state_n;
      // write wins a tie; the held read is taken after GNT
      if (r_state == S_IDLE && w_req) begin
        r_op_wr <= bus.wr_req;
        r_addr  <= bus.addr;
        r_wline <= bus.wr_line;
        r_cnt   <= 8'(LATENCY - 1);
      end
      if (r_state == S_BUSY && r_cnt != 8'd0)
        r_cnt <= r_cnt - 8'd1;
      if (w_done) begin
        if (r_op_wr) begin
          r_wr_count <= r_wr_count + 32'd1;
        end else begin
          r_rd_line  <= r_mem[r_addr];
          r_rd_count <= r_rd_count + 32'd1;
        end
      end
    end
  end

  // array contents survive reset
  always_ff @(posedge clk) begin
    if (rst && w_done && r_op_wr)
      r_mem[r_addr] <= r_wline;
  end

  assign bus.rd_line  = r_rd_line;
  assign bus.gnt      = (r_state == S_GNT);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.rd_count = r_rd_count;
  assign bus.wr_count = r_wr_count;
endmodule

// File: tb/tb_main_mem_line.sv
// Directed bench for main_mem_line: latency, ordering, churn, reset abort,
// and a LATENCY=1 build.
module tb_main_mem_line;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  main_mem_line_if #(.LINE_ADDR_LEN(1), .ADDR_LEN(12)) bus ();
  main_mem_line_if #(.LINE_ADDR_LEN(1), .ADDR_LEN(12)) bus2 ();

  main_mem_line #(
    .LINE_ADDR_LEN(1), .ADDR_LEN(12), .LATENCY(10)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  main_mem_line #(
    .LINE_ADDR_LEN(1), .ADDR_LEN(12), .LATENCY(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // counts edges; c equals the cycle number in which gnt is first seen
  task automatic wait_gnt(input bit sel, input int start, output int c);
    bit seen;
    seen = 1'b0;
    c = start;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      c++;
      seen = sel ? bus2.gnt : bus.gnt;
    end
    if (!seen) chk("gnt_timeout", 64'd0, 64'd1);
  endtask

  task automatic access(input logic w, input logic [11:0] a,
                        input logic [63:0] d, output int c);
    bus.wr_req  = w;
    bus.rd_req  = ~w;
    bus.addr    = a;
    bus.wr_line = d;
    wait_gnt(1'b0, 0, c);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    @(posedge clk); #1;
    chk("gnt_one_cycle", {63'd0, bus.gnt}, 64'd0);
  endtask

  int  c;
  bit  any_gnt;

  initial begin
    rst          = 1'b0;
    bus.rd_req   = 1'b1;
    bus.wr_req   = 1'b0;
    bus.addr     = '0;
    bus.wr_line  = '0;
    bus2.rd_req  = 1'b0;
    bus2.wr_req  = 1'b0;
    bus2.addr    = '0;
    bus2.wr_line = '0;

    // 1: reset holds everything quiet even with a request pending
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", {63'd0, bus.gnt}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_rd_line", bus.rd_line, 64'd0);
    chk("rst_rd_count", {32'd0, bus.rd_count}, 64'd0);
    chk("rst_wr_count", {32'd0, bus.wr_count}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_accept", {63'd0, bus.busy}, 64'd1);
    wait_gnt(1'b0, 1, c);
    chk("rst_first_gnt", c, 11);
    bus.rd_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // 2: write then read back
    access(1'b1, 12'h005, 64'hDEADBEEF_12345678, c);
    chk("wr_gnt_cycle", c, 11);
    access(1'b0, 12'h005, 64'd0, c);
    chk("rd_gnt_cycle", c, 11);
    chk("rd_data", bus.rd_line, 64'hDEADBEEF_12345678);
    chk("rd_count_1", {32'd0, bus.rd_count}, 64'd1);
    chk("wr_count_1", {32'd0, bus.wr_count}, 64'd1);

    // 3: simultaneous requests, writeback then refill
    bus.rd_req  = 1'b1;
    bus.wr_req  = 1'b1;
    bus.addr    = 12'h003;
    bus.wr_line = 64'hA5A5A5A5_5A5A5A5A;
    wait_gnt(1'b0, 0, c);
    chk("sim_wr_gnt", c, 11);
    chk("sim_wr_count", {32'd0, bus.wr_count}, 64'd2);
    bus.wr_req = 1'b0;
    @(posedge clk); #1;
    chk("sim_idle_gap", {63'd0, bus.busy}, 64'd0);
    wait_gnt(1'b0, 12, c);
    chk("sim_rd_gnt", c, 23);
    chk("sim_rd_data", bus.rd_line, 64'hA5A5A5A5_5A5A5A5A);
    bus.rd_req = 1'b0;
    @(posedge clk); #1;
    chk("sim_rd_count", {32'd0, bus.rd_count}, 64'd2);

    // 4: input churn after acceptance
    access(1'b1, 12'h007, 64'h77777777_77777777, c);
    bus.rd_req = 1'b1;
    bus.addr   = 12'h005;
    repeat (2) @(posedge clk);
    #1;
    bus.rd_req = 1'b0;
    bus.addr   = 12'h007;
    wait_gnt(1'b0, 2, c);
    chk("churn_gnt", c, 11);
    chk("churn_data", bus.rd_line, 64'hDEADBEEF_12345678);
    @(posedge clk); #1;

    // 5: reset in the middle of a write
    access(1'b1, 12'h009, 64'h00000000_11112222, c);
    bus.wr_req  = 1'b1;
    bus.addr    = 12'h009;
    bus.wr_line = 64'hFFFFFFFF_FFFFFFFF;
    repeat (5) @(posedge clk);
    #1;
    bus.wr_req = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_gnt", {63'd0, bus.gnt}, 64'd0);
    chk("abort_wr_count", {32'd0, bus.wr_count}, 64'd0);
    rst = 1'b1;
    any_gnt = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      any_gnt |= bus.gnt;
    end
    chk("abort_no_gnt", {63'd0, any_gnt}, 64'd0);
    access(1'b0, 12'h009, 64'd0, c);
    chk("abort_old_data", bus.rd_line, 64'h00000000_11112222);
    chk("abort_rd_count", {32'd0, bus.rd_count}, 64'd1);

    // 6: LATENCY=1 build
    bus2.wr_req  = 1'b1;
    bus2.addr    = 12'h001;
    bus2.wr_line = 64'h0123_4567_89AB_CDEF;
    wait_gnt(1'b1, 0, c);
    chk("l1_wr_gnt", c, 2);
    bus2.wr_req = 1'b0;
    bus2.rd_req = 1'b1;
    wait_gnt(1'b1, 0, c);
    chk("l1_rd_gnt_a", c, 3);
    chk("l1_rd_data", bus2.rd_line, 64'h0123_4567_89AB_CDEF);
    wait_gnt(1'b1, 0, c);
    chk("l1_rd_gnt_b", c, 3);
    bus2.rd_req = 1'b0;
    @(posedge clk); #1;
    chk("l1_rd_count", {32'd0, bus2.rd_count}, 64'd2);
    chk("l1_wr_count", {32'd0, bus2.wr_count}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
